// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: fetch port, data port and memory side.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256
);
  localparam int AW = $clog2(MEM_SIZE);

  logic                 if_req;
  logic [AW-1:0]        if_addr;
  logic                 if_ready;
  logic                 if_rvalid;
  logic [MEM_WIDTH-1:0] if_rdata;

  logic                 dm_req;
  logic                 dm_we;
  logic [AW-1:0]        dm_addr;
  logic [MEM_WIDTH-1:0] dm_wdata;
  logic                 dm_ready;
  logic                 dm_rvalid;
  logic [MEM_WIDTH-1:0] dm_rdata;

  logic [AW-1:0]        mem_addr;
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [MEM_WIDTH-1:0] mem_write_val;
  logic [MEM_WIDTH-1:0] mem_read_val;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rvalid, dm_rdata,
    output mem_addr, mem_read_en,
    output mem_write_en, mem_write_val,
    input  mem_read_val
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rvalid, dm_rdata,
    input  mem_addr, mem_read_en,
    input  mem_write_en, mem_write_val,
    output mem_read_val
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter onto one single-cycle memory: data port first,
// fetch port guaranteed a slot after MAX_DSTREAK data grants.
module mem_port_arbiter #(
  parameter int MEM_WIDTH   = 32,
  parameter int MEM_SIZE    = 256,
  parameter int MAX_DSTREAK = 3
) (
  input logic           clk,
  input logic           rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam int SW =
    (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          own_vld_q, own_vld_d;
  logic          own_dm_q, own_dm_d;

  logic fetch_first;
  logic gnt_if;
  logic gnt_dm;

  // Ready is gated by rst_n so nothing is accepted while in reset.
  always_comb begin
    fetch_first = bus.if_req && (dstreak_q == SMAX);
    gnt_dm      = rst_n && bus.dm_req && !fetch_first;
    gnt_if      = rst_n && bus.if_req && !gnt_dm;
  end

  always_comb begin
    bus.if_ready      = gnt_if;
    bus.dm_ready      = gnt_dm;
    bus.mem_addr      = '0;
    bus.mem_read_en   = 1'b0;
    bus.mem_write_en  = 1'b0;
    bus.mem_write_val = '0;
    unique case (1'b1)
      gnt_if: begin
        bus.mem_addr    = bus.if_addr;
        bus.mem_read_en = 1'b1;
      end
      gnt_dm: begin
        bus.mem_addr     = bus.dm_addr;
        bus.mem_read_en  = !bus.dm_we;
        bus.mem_write_en = bus.dm_we;
        if (bus.dm_we) begin
          bus.mem_write_val = bus.dm_wdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    dstreak_d = dstreak_q;
    if (!bus.if_req || gnt_if) begin
      dstreak_d = '0;
    end else if (gnt_dm && dstreak_q != SMAX) begin
      dstreak_d = dstreak_q + 1'b1;
    end
    own_vld_d = gnt_if || (gnt_dm && !bus.dm_we);
    own_dm_d  = gnt_dm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstreak_q <= '0;
      own_vld_q <= 1'b0;
      own_dm_q  <= 1'b0;
    end else begin
      dstreak_q <= dstreak_d;
      own_vld_q <= own_vld_d;
      own_dm_q  <= own_dm_d;
    end
  end

  // Memory returns data one cycle after the read strobe.
  always_comb begin
    bus.if_rvalid = own_vld_q && !own_dm_q;
    bus.dm_rvalid = own_vld_q && own_dm_q;
    bus.if_rdata  = bus.mem_read_val;
    bus.dm_rdata  = bus.mem_read_val;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level
// reference model and a simple backing memory.
module tb_mem_port_arbiter;
  localparam int MW = 32;
  localparam int MS = 256;
  localparam int MX = 3;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) bus();

  mem_port_arbiter #(
    .MEM_WIDTH(MW), .MEM_SIZE(MS), .MAX_DSTREAK(MX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_val(int a);
    if (a == 16) return 32'hDEADBEEF;
    return 32'hC0DE0000 + 32'(a) * 32'h11;
  endfunction

  // Backing memory driven by the DUT's memory side.
  logic [31:0] env_mem [int];
  always @(posedge clk) begin
    int a;
    a = int'(bus.mem_addr);
    if (bus.mem_read_en)
      bus.mem_read_val <= env_mem.exists(a) ? env_mem[a] : init_val(a);
    if (bus.mem_write_en)
      env_mem[a] = bus.mem_write_val;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  logic [31:0] mmem [int];
  int          streak = 0;
  int          pend = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [31:0] exp_data = '0;
  logic [7:0]  g_log = '0;
  logic [7:0]  r_log = '0;
  bit          log_prev = 0;
  bit          log_g = 0;
  bit          pat_chk = 0;

  always @(negedge clk) begin : cmp
    logic e_ir, e_dr, e_irv, e_drv, e_re, e_we;
    logic [AW-1:0] e_a;
    logic [31:0] e_wv;
    bit fw, gi, gd;
    int a;
    e_ir = 0; e_dr = 0; e_irv = 0; e_drv = 0;
    e_re = 0; e_we = 0; e_a = '0; e_wv = '0;
    gi = 0; gd = 0; fw = 0;
    if (!rst_n) begin
      streak = 0;
      pend = 0;
    end else begin
      e_irv = (pend == 1);
      e_drv = (pend == 2);
      fw = bus.if_req && (!bus.dm_req || streak == MX);
      gi = fw;
      gd = bus.dm_req && !fw;
      e_ir = gi;
      e_dr = gd;
      if (gi) begin
        e_a = bus.if_addr;
        e_re = 1;
      end else if (gd) begin
        e_a = bus.dm_addr;
        e_re = !bus.dm_we;
        e_we = bus.dm_we;
        e_wv = bus.dm_we ? bus.dm_wdata : '0;
      end
    end
    chk("if_ready", bus.if_ready, e_ir);
    chk("dm_ready", bus.dm_ready, e_dr);
    chk("if_rvalid", bus.if_rvalid, e_irv);
    chk("dm_rvalid", bus.dm_rvalid, e_drv);
    chk("mem_addr", bus.mem_addr, e_a);
    chk("mem_read_en", bus.mem_read_en, e_re);
    chk("mem_write_en", bus.mem_write_en, e_we);
    chk("mem_write_val", bus.mem_write_val, e_wv);
    chk("rvalid_excl", bus.if_rvalid & bus.dm_rvalid, 0);
    if (e_irv) chk("if_rdata", bus.if_rdata, exp_data);
    if (e_drv) chk("dm_rdata", bus.dm_rdata, exp_data);
    if (e_irv && pend_addr == 8'h10)
      chk("lit_fetch_10", bus.if_rdata, 32'hDEADBEEF);
    if (e_drv && pend_addr == 8'h20 && mmem.exists(32))
      chk("lit_read_20", bus.dm_rdata, 32'h12345678);

    if (log_prev) r_log = {r_log[6:0], bus.dm_rvalid};
    if (log_g) g_log = {g_log[6:0], bus.dm_ready};
    log_prev = log_g;
    if (pat_chk) begin
      chk("grant_pattern", g_log, 8'b11101110);
      chk("rvalid_pattern", r_log, 8'b11101110);
    end

    if (rst_n) begin
      if (!bus.if_req || gi) streak = 0;
      else if (gd && streak < MX) streak++;
      pend = 0;
      if (gi) begin
        a = int'(bus.if_addr);
        pend = 1;
        pend_addr = bus.if_addr;
        exp_data = mmem.exists(a) ? mmem[a] : init_val(a);
      end else if (gd) begin
        a = int'(bus.dm_addr);
        if (bus.dm_we) begin
          mmem[a] = bus.dm_wdata;
        end else begin
          pend = 2;
          pend_addr = bus.dm_addr;
          exp_data = mmem.exists(a) ? mmem[a] : init_val(a);
        end
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.if_req = 0;
    bus.dm_req = 0;
    bus.dm_we  = 0;
  endtask

  task automatic fetch(logic [AW-1:0] a);
    bus.if_req = 1;
    bus.if_addr = a;
  endtask

  task automatic data(bit we, logic [AW-1:0] a, logic [31:0] d);
    bus.dm_req = 1;
    bus.dm_we = we;
    bus.dm_addr = a;
    bus.dm_wdata = d;
  endtask

  initial begin
    rst_n = 0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    cyc(3);
    rst_n = 1;
    cyc(1);
    // fetch-only read
    fetch(8'h10); cyc(1);
    idle(); cyc(2);
    // data write then read back
    data(1, 8'h20, 32'h12345678); cyc(1);
    idle(); cyc(2);
    data(0, 8'h20, 32'h0); cyc(1);
    idle(); cyc(1);
    // continuous conflict
    fetch(8'h30); data(0, 8'h40, 32'h0);
    log_g = 1;
    cyc(8);
    idle(); log_g = 0;
    cyc(1);
    pat_chk = 1; cyc(1); pat_chk = 0;
    // alternating reads
    fetch(8'h10); cyc(1);
    idle(); data(0, 8'h50, 32'h0); cyc(1);
    idle(); fetch(8'h11); cyc(1);
    idle(); data(0, 8'h51, 32'h0); cyc(1);
    idle(); cyc(2);
    // streak cleared by a cycle without fetch request
    fetch(8'h12); data(0, 8'h60, 32'h0); cyc(2);
    bus.if_req = 0; cyc(1);
    bus.if_req = 1; cyc(4);
    idle(); cyc(1);
    // write under conflict, then conflict with writes only
    fetch(8'h13); data(1, 8'h70, 32'hA5A5_5A5A); cyc(5);
    idle(); cyc(1);
    // reset right after an accepted data read
    data(0, 8'h40, 32'h0); cyc(1);
    idle(); rst_n = 0; cyc(2);
    rst_n = 1; fetch(8'h10); cyc(1);
    idle(); cyc(1);
    // reset asserted inside a requesting cycle
    data(0, 8'h41, 32'h0); #2 rst_n = 0;
    cyc(2);
    idle(); rst_n = 1; cyc(1);
    fetch(8'h14); cyc(1);
    idle(); cyc(1);
    // idle, then the streak must start from zero
    cyc(5);
    fetch(8'h15); data(0, 8'h42, 32'h0); cyc(4);
    idle(); cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_WIDTH, default 32, is the data word width in bits.
REQ-002 Parameter MEM_SIZE, default 256, is the memory depth in words; AW = $clog2(MEM_SIZE).
REQ-003 Parameter MAX_DSTREAK, default 3, is the maximum number of consecutive data-port grants while a fetch is pending.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  fetch-port read request.
REQ-007 if_addr  input  AW  fetch word address.
REQ-008 if_ready  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  fetch read data valid.
REQ-010 if_rdata  output  MEM_WIDTH  fetch read data.
REQ-011 dm_req  input  1  data-port request.
REQ-012 dm_we  input  1  data-port request is a write (1) or a read (0).
REQ-013 dm_addr  input  AW  data word address.
REQ-014 dm_wdata  input  MEM_WIDTH  write data.
REQ-015 dm_ready  output  1  data request accepted this cycle.
REQ-016 dm_rvalid  output  1  data read data valid.
REQ-017 dm_rdata  output  MEM_WIDTH  data read data.
REQ-018 mem_addr  output  AW  shared memory address.
REQ-019 mem_read_en  output  1  memory read strobe.
REQ-020 mem_write_en  output  1  memory write strobe.
REQ-021 mem_write_val  output  MEM_WIDTH  memory write data.
REQ-022 mem_read_val  input  MEM_WIDTH  memory read data, valid one cycle after mem_read_en.

Function
REQ-023 The block SHALL grant at most one request per cycle; accept means req && ready in the same cycle.
REQ-024 Ready SHALL be combinational from the current req inputs and registered arbitration state; the granted port's address, data and strobes SHALL drive mem_* in the same cycle.
REQ-025 The default priority SHALL be: the data port wins when both ports request.
REQ-026 A saturating counter dstreak (0..MAX_DSTREAK) SHALL increment on each data grant made while if_req=1.
REQ-027 dstreak SHALL clear on any fetch grant and on any cycle with if_req=0.
REQ-028 When dstreak==MAX_DSTREAK and if_req=1, the fetch port SHALL win that cycle's arbitration.
REQ-029 A fetch grant SHALL assert mem_read_en=1 and mem_write_en=0.
REQ-030 A data grant with dm_we=1 SHALL assert mem_write_en=1 and mem_read_en=0 with mem_write_val=dm_wdata; the write SHALL complete on acceptance and produce no rvalid.
REQ-031 A data grant with dm_we=0 SHALL assert mem_read_en=1 and mem_write_en=0.
REQ-032 A response-owner register SHALL record {valid, port} for each read grant.
REQ-033 One cycle after each read grant, exactly one of if_rvalid or dm_rvalid SHALL pulse for one cycle, according to the recorded owner.
REQ-034 Both if_rdata and dm_rdata SHALL present mem_read_val; each SHALL be meaningful only while its rvalid is high.
REQ-035 Back-to-back grants SHALL sustain one access per cycle, so throughput is 1 and read latency is 1 cycle.
REQ-036 With no grant, mem_read_en=0, mem_write_en=0, mem_addr=0 and mem_write_val=0.
REQ-037 Requesters SHALL hold req, addr, we and wdata stable until accepted; the block SHALL NOT latch an unaccepted request.

Reset
REQ-038 While rst_n=0, dstreak=0, the response owner is invalid, if_rvalid=0 and dm_rvalid=0, and all ready and mem strobes are 0.
REQ-039 A read granted in the cycle rst_n falls SHALL produce no rvalid after reset is released.
REQ-040 Arbitration SHALL resume on the first rising clk edge after rst_n rises.

Verification
REQ-041 Fetch-only read: if_req=1, if_addr=0x10, mem_read_val=0xDEADBEEF -> if_ready=1 with mem_addr=0x10 and mem_read_en=1; the next cycle if_rvalid=1 and if_rdata=0xDEADBEEF.
REQ-042 Data write: dm_req=1, dm_we=1, dm_addr=0x20, dm_wdata=0x12345678 -> dm_ready=1, mem_write_en=1 and mem_write_val=0x12345678; no dm_rvalid follows.
REQ-043 Continuous conflict: if_req and dm_req (read) held high for 8 cycles with MAX_DSTREAK=3 -> grant pattern D,D,D,I,D,D,D,I; the rvalid pulses follow the same pattern, each one cycle later.
REQ-044 Alternating reads: back-to-back fetch then data reads -> if_rvalid and dm_rvalid pulse on consecutive cycles with correct data and never both high.
REQ-045 Reset mid-operation: rst_n asserted in the same cycle as a data read grant -> dm_rvalid=0 and all strobes 0 during reset; after release, a fresh fetch read completes normally.
REQ-046 Idle: no requests for 5 cycles -> all ready, rvalid and mem strobes are 0, and dstreak stays 0.
